// File: rtl/vga_tty.sv
// vga_tty: converts a character byte stream into character-memory writes.
// It tracks the cursor, decodes control codes, clears the next line when the
// cursor advances to a new row, and clears the whole screen on form feed.
// Optional feature: define VGA_TTY_TAB_EN so that HT (0x09) moves the cursor
// to the next multiple of 8. Without it, HT is accepted and ignored.
module vga_tty #(
  parameter int ROWS = 30,
  parameter int COLS = 70
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_char,
  input  logic [2:0]  fg_color,
  input  logic [2:0]  bg_color,
  output logic        sel,
  output logic        we,
  output logic [31:0] addr,
  output logic [31:0] din,
  output logic [4:0]  cur_row,
  output logic [6:0]  cur_col,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_LINE, S_SCREEN} state_t;

  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);
  localparam logic [6:0] COL_LAST = 7'(COLS - 1);
  localparam logic [7:0] COL_END  = 8'(COLS);

  state_t     state, nxt_state;
  logic [4:0] nxt_row, clr_row, nxt_clr_row, w_row, row_inc;
  logic [6:0] nxt_col, clr_col, nxt_clr_col, w_col;
  logic [7:0] col_inc, w_chr;
  logic [2:0] fg_q, bg_q, w_fg, w_bg;
  logic       clr_last, nxt_last, w_en, adv;
`ifdef VGA_TTY_TAB_EN
  logic [7:0] tab_col;
`endif

  assign col_inc = {1'b0, cur_col} + 8'd1;
  assign row_inc = (cur_row == ROW_LAST) ? 5'd0 : cur_row + 5'd1;
`ifdef VGA_TTY_TAB_EN
  assign tab_col = {1'b0, cur_col | 7'h07} + 8'd1;
`endif

  // State, cursor, clear counters and the registered write port.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cur_row  <= '0;
      cur_col  <= '0;
      fg_q     <= '0;
      bg_q     <= '0;
      clr_row  <= '0;
      clr_col  <= '0;
      clr_last <= 1'b0;
      sel      <= 1'b0;
      we       <= 1'b0;
      addr     <= '0;
      din      <= '0;
    end else begin
      state    <= nxt_state;
      cur_row  <= nxt_row;
      cur_col  <= nxt_col;
      fg_q     <= w_fg;
      bg_q     <= w_bg;
      clr_row  <= nxt_clr_row;
      clr_col  <= nxt_clr_col;
      clr_last <= nxt_last;
      sel      <= w_en;
      we       <= w_en;
      addr     <= w_en ? {19'b0, w_col, w_row, 1'b0} : 32'd0;
      din      <= w_en ? {18'b0, w_bg, w_fg, w_chr} : 32'd0;
    end
  end

  // Byte decode and clear sequencing; produces at most one write per cycle.
  // Clear states linger one cycle after their last write is issued so that
  // busy covers every visible clear write.
  always_comb begin
    nxt_state   = state;
    nxt_row     = cur_row;
    nxt_col     = cur_col;
    nxt_clr_row = clr_row;
    nxt_clr_col = clr_col;
    nxt_last    = clr_last;
    w_en        = 1'b0;
    w_row       = cur_row;
    w_col       = cur_col;
    w_chr       = 8'h20;
    w_fg        = fg_q;
    w_bg        = bg_q;
    adv         = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          w_fg = fg_color;
          w_bg = bg_color;
          if (in_char >= 8'h20 && in_char <= 8'h7E) begin
            w_en  = 1'b1;
            w_chr = in_char;
            if (col_inc == COL_END) begin
              nxt_col = '0;
              adv     = 1'b1;
            end else begin
              nxt_col = col_inc[6:0];
            end
          end else begin
            case (in_char)
              8'h0A: begin
                nxt_col = '0;
                adv     = 1'b1;
              end
              8'h0D: nxt_col = '0;
              8'h08: begin
                if (cur_col != '0) begin
                  nxt_col = cur_col - 7'd1;
                  w_en    = 1'b1;
                  w_col   = cur_col - 7'd1;
                end
              end
              8'h0C: begin
                nxt_row     = '0;
                nxt_col     = '0;
                nxt_clr_row = '0;
                nxt_clr_col = '0;
                nxt_last    = 1'b0;
                nxt_state   = S_SCREEN;
              end
`ifdef VGA_TTY_TAB_EN
              8'h09: begin
                if (tab_col >= COL_END) begin
                  nxt_col = '0;
                  adv     = 1'b1;
                end else begin
                  nxt_col = tab_col[6:0];
                end
              end
`endif
              default: ;
            endcase
          end
          if (adv) begin
            nxt_row     = row_inc;
            nxt_clr_col = '0;
            nxt_last    = 1'b0;
            nxt_state   = S_LINE;
          end
        end
      end
      S_LINE: begin
        if (clr_last) begin
          nxt_state = S_IDLE;
        end else begin
          w_en  = 1'b1;
          w_col = clr_col;
          if (clr_col == COL_LAST) nxt_last = 1'b1;
          else nxt_clr_col = clr_col + 7'd1;
        end
      end
      S_SCREEN: begin
        if (clr_last) begin
          nxt_state = S_IDLE;
        end else begin
          w_en  = 1'b1;
          w_row = clr_row;
          w_col = clr_col;
          if (clr_col == COL_LAST) begin
            nxt_clr_col = '0;
            if (clr_row == ROW_LAST) nxt_last = 1'b1;
            else nxt_clr_row = clr_row + 5'd1;
          end else begin
            nxt_clr_col = clr_col + 7'd1;
          end
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // Handshake and status flags follow the state directly.
  always_comb begin
    in_ready = (state == S_IDLE);
    busy     = (state != S_IDLE);
  end

endmodule

// File: tb/tb_vga_tty.sv
// Directed bench for vga_tty (ROWS=30, COLS=70).
module tb_vga_tty;
  logic        clock, reset, in_valid, in_ready;
  logic [7:0]  in_char;
  logic [2:0]  fg_color, bg_color;
  logic        sel, we, busy;
  logic [31:0] addr, din;
  logic [4:0]  cur_row;
  logic [6:0]  cur_col;
  int total = 0;
  int bad = 0;

  vga_tty #(.ROWS(30), .COLS(70)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_char(in_char), .fg_color(fg_color), .bg_color(bg_color),
    .sel(sel), .we(we), .addr(addr), .din(din),
    .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mk_addr(input int r, input int c);
    return {19'b0, 7'(c), 5'(r), 1'b0};
  endfunction

  function automatic logic [31:0] mk_din(input logic [2:0] b, input logic [2:0] f, input logic [7:0] ch);
    return {18'b0, b, f, ch};
  endfunction

  // Offer a byte at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] c, input logic [2:0] f, input logic [2:0] b);
    int n = 0;
    in_char = c; fg_color = f; bg_color = b; in_valid = 1'b1;
    while (!in_ready && n < 3000) begin @(negedge clock); n++; end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL send_timeout char=%h in_ready=%b expected 1", c, in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; in_valid = 1'b0; in_char = '0; fg_color = '0; bg_color = '0;
    repeat (3) @(negedge clock);
    total++;
    if ({sel, we, addr, din, cur_row, cur_col, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs sel=%b we=%b addr=%h din=%h row=%0d col=%0d busy=%b expected all 0",
               sel, we, addr, din, cur_row, cur_col, busy);
    end
    reset = 1'b1;
    @(negedge clock);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready in_ready=%b expected 1", in_ready); end
  endtask

  task automatic test_char;
    send_byte(8'h41, 3'd7, 3'd1);
    total++;
    if ({sel, we, addr, din} !== {2'b11, 32'h0, 32'h0000_0F41}) begin
      bad++;
      $display("FAIL char_write sel=%b we=%b addr=%h din=%h expected 1 1 0 00000f41", sel, we, addr, din);
    end
    total++;
    if ({cur_row, cur_col, in_ready} !== {5'd0, 7'd1, 1'b1}) begin
      bad++;
      $display("FAIL char_cursor row=%0d col=%0d ready=%b expected 0 1 1", cur_row, cur_col, in_ready);
    end
    @(negedge clock);
    total++;
    if (sel !== 1'b0) begin bad++; $display("FAIL char_single sel=%b expected 0", sel); end
  endtask

  // Check a 70-write line clear of row r with the given colours, then idle.
  task automatic check_line_clear(input string nm, input int r, input logic [2:0] f, input logic [2:0] b);
    for (int c = 0; c < 70; c++) begin
      @(negedge clock);
      total++;
      if ({sel, we, addr, din, busy, in_ready} !== {2'b11, mk_addr(r, c), mk_din(b, f, 8'h20), 2'b10}) begin
        bad++;
        $display("FAIL %s col=%0d sel=%b addr=%h din=%h busy=%b ready=%b expected 1 %h %h 1 0",
                 nm, c, sel, addr, din, busy, in_ready, mk_addr(r, c), mk_din(b, f, 8'h20));
      end
    end
    @(negedge clock);
    total++;
    if ({sel, busy, in_ready} !== 3'b001) begin
      bad++;
      $display("FAIL %s_end sel=%b busy=%b ready=%b expected 0 0 1", nm, sel, busy, in_ready);
    end
  endtask

  task automatic test_wrap;
    repeat (68) send_byte(8'h2E, 3'd2, 3'd5);
    send_byte(8'h5A, 3'd2, 3'd5);
    total++;
    if ({sel, we, addr, din} !== {2'b11, 32'h0000_1140, 32'h0000_2A5A}) begin
      bad++;
      $display("FAIL wrap_char sel=%b we=%b addr=%h din=%h expected 1 1 00001140 00002a5a", sel, we, addr, din);
    end
    total++;
    if ({cur_row, cur_col, busy, in_ready} !== {5'd1, 7'd0, 2'b10}) begin
      bad++;
      $display("FAIL wrap_cursor row=%0d col=%0d busy=%b ready=%b expected 1 0 1 0", cur_row, cur_col, busy, in_ready);
    end
    check_line_clear("wrap_clear", 1, 3'd2, 3'd5);
  endtask

  task automatic test_lf_wrap;
    repeat (28) send_byte(8'h0A, 3'd0, 3'd0);
    repeat (5) send_byte(8'h78, 3'd7, 3'd0);
    total++;
    if ({cur_row, cur_col} !== {5'd29, 7'd5}) begin
      bad++;
      $display("FAIL lf_setup row=%0d col=%0d expected 29 5", cur_row, cur_col);
    end
    send_byte(8'h0A, 3'd1, 3'd0);
    total++;
    if ({sel, cur_row, cur_col, busy} !== {1'b0, 5'd0, 7'd0, 1'b1}) begin
      bad++;
      $display("FAIL lf_wrap sel=%b row=%0d col=%0d busy=%b expected 0 0 0 1", sel, cur_row, cur_col, busy);
    end
    check_line_clear("lf_clear", 0, 3'd1, 3'd0);
  endtask

  task automatic test_bs_cr;
    send_byte(8'h61, 3'd7, 3'd7);
    send_byte(8'h62, 3'd7, 3'd7);
    send_byte(8'h63, 3'd7, 3'd7);
    send_byte(8'h08, 3'd5, 3'd0);
    total++;
    if ({sel, we, addr, din, cur_row, cur_col} !== {2'b11, 32'h80, 32'h0520, 5'd0, 7'd2}) begin
      bad++;
      $display("FAIL bs_write sel=%b addr=%h din=%h row=%0d col=%0d expected 1 00000080 00000520 0 2",
               sel, addr, din, cur_row, cur_col);
    end
    send_byte(8'h0D, 3'd5, 3'd0);
    total++;
    if ({sel, cur_row, cur_col} !== {1'b0, 5'd0, 7'd0}) begin
      bad++;
      $display("FAIL cr sel=%b row=%0d col=%0d expected 0 0 0", sel, cur_row, cur_col);
    end
    send_byte(8'h08, 3'd5, 3'd0);
    total++;
    if ({sel, cur_row, cur_col, in_ready} !== {1'b0, 5'd0, 7'd0, 1'b1}) begin
      bad++;
      $display("FAIL bs_col0 sel=%b row=%0d col=%0d ready=%b expected 0 0 0 1", sel, cur_row, cur_col, in_ready);
    end
  endtask

  task automatic test_ff;
    int nw = 0;
    int n = 0;
    logic done = 1'b0;
    send_byte(8'h71, 3'd7, 3'd7);
    send_byte(8'h0C, 3'd3, 3'd4);
    total++;
    if ({sel, cur_row, cur_col, busy} !== {1'b0, 5'd0, 7'd0, 1'b1}) begin
      bad++;
      $display("FAIL ff_enter sel=%b row=%0d col=%0d busy=%b expected 0 0 0 1", sel, cur_row, cur_col, busy);
    end
    in_char = 8'h42; fg_color = 3'd6; bg_color = 3'd2; in_valid = 1'b1;
    while (!done && n < 2300) begin
      @(negedge clock);
      n++;
      if (sel) begin
        total++;
        if ({addr, din, busy} !== {mk_addr(nw / 70, nw % 70), mk_din(3'd4, 3'd3, 8'h20), 1'b1}) begin
          bad++;
          $display("FAIL ff_write n=%0d addr=%h din=%h busy=%b expected %h %h 1",
                   nw, addr, din, busy, mk_addr(nw / 70, nw % 70), mk_din(3'd4, 3'd3, 8'h20));
        end
        nw++;
      end
      if (in_ready) done = 1'b1;
    end
    total++;
    if (nw !== 2100) begin bad++; $display("FAIL ff_count writes=%0d expected 2100", nw); end
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    total++;
    if ({sel, we, addr, din, cur_row, cur_col} !== {2'b11, 32'h0, 32'h1642, 5'd0, 7'd1}) begin
      bad++;
      $display("FAIL ff_held_byte sel=%b addr=%h din=%h row=%0d col=%0d expected 1 0 00001642 0 1",
               sel, addr, din, cur_row, cur_col);
    end
  endtask

  task automatic test_reset_mid_clear;
    send_byte(8'h0C, 3'd1, 3'd1);
    repeat (10) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({sel, we, addr, din, cur_row, cur_col, busy} !== '0) begin
      bad++;
      $display("FAIL midclr_async sel=%b addr=%h din=%h row=%0d col=%0d busy=%b expected all 0",
               sel, addr, din, cur_row, cur_col, busy);
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    total++;
    if ({in_ready, busy} !== 2'b10) begin
      bad++;
      $display("FAIL midclr_ready ready=%b busy=%b expected 1 0", in_ready, busy);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      total++;
      if ({sel, we, busy} !== 3'b000) begin
        bad++;
        $display("FAIL midclr_quiet cyc=%0d sel=%b we=%b busy=%b expected 0 0 0", i, sel, we, busy);
      end
    end
  endtask

  task automatic test_tab;
    logic [6:0] exp_col;
`ifdef VGA_TTY_TAB_EN
    exp_col = 7'd8;
`else
    exp_col = 7'd3;
`endif
    send_byte(8'h61, 3'd2, 3'd2);
    send_byte(8'h62, 3'd2, 3'd2);
    send_byte(8'h63, 3'd2, 3'd2);
    send_byte(8'h09, 3'd2, 3'd2);
    total++;
    if ({sel, cur_row, cur_col, in_ready} !== {1'b0, 5'd0, exp_col, 1'b1}) begin
      bad++;
      $display("FAIL tab sel=%b row=%0d col=%0d ready=%b expected 0 0 %0d 1", sel, cur_row, cur_col, in_ready, exp_col);
    end
  endtask

  initial begin
    test_reset;
    test_char;
    test_wrap;
    test_lf_wrap;
    test_bs_cr;
    test_ff;
    test_reset_mid_clear;
    test_tab;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
